// File: rtl/apb_mem_slave_p_if.sv
// APB3 bus bundle for apb_mem_slave_p: master drives the request side, slave returns data/ready/error.
interface apb_mem_slave_p_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              PSELx;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [NB-1:0]     PSTRB;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (output PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
                  output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_mem_slave_p.sv
// APB3 scratch RAM slave: programmable wait states, range/alignment decode with PSLVERR.
// Define APB_SLV_PSTRB_EN for byte-strobe writes and the APB4 read-strobe error.
module apb_mem_slave_p #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH       = 8,
  parameter int                WAIT_STATES = 0,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input logic              PCLK,
  input logic              PRESET,
  apb_mem_slave_p_if.slave apb
);
  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int IW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] off;
  logic [IW-1:0]     idx;
  logic              below, hi, mis, strb_err, err, commit;

  assign off   = apb.PADDR - BASE_ADDR;
  assign idx   = off[LB+IW-1:LB];
  assign below = apb.PADDR < BASE_ADDR;
  assign hi    = |off[ADDR_W-1:LB+IW];

  generate
    if (LB > 0) begin : g_mis
      assign mis = |off[LB-1:0];
    end else begin : g_nomis
      assign mis = 1'b0;
    end
  endgenerate

`ifdef APB_SLV_PSTRB_EN
  assign strb_err = ~apb.PWRITE & (|apb.PSTRB);
`else
  logic unused_pstrb;
  assign unused_pstrb = ^apb.PSTRB;
  assign strb_err     = 1'b0;
`endif

  assign err = below | hi | mis | strb_err;

  // The edge that moves the FSM into RESP is the one that commits the access.
  assign commit = apb.PSELx &
                  (((state == S_IDLE) & apb.PENABLE & (WAIT_STATES == 0)) |
                   ((state == S_WAIT) & (cnt == 4'd0)));

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      apb.PRDATA  <= '0;
      apb.PREADY  <= 1'b0;
      apb.PSLVERR <= 1'b0;
    end else begin
      if (commit) begin
        apb.PREADY  <= 1'b1;
        apb.PSLVERR <= err;
        if (!apb.PWRITE) apb.PRDATA <= err ? '0 : mem[idx];
      end
      case (state)
        S_IDLE: if (apb.PSELx && apb.PENABLE) begin
          if (WAIT_STATES == 0) state <= S_RESP;
          else begin
            state <= S_WAIT;
            cnt   <= CNT_INIT;
          end
        end
        S_WAIT: begin
          if (!apb.PSELx)        state <= S_IDLE;
          else if (cnt != 4'd0)  cnt   <= cnt - 4'd1;
          else                   state <= S_RESP;
        end
        S_RESP: begin
          state       <= S_IDLE;
          apb.PREADY  <= 1'b0;
          apb.PSLVERR <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Storage is intentionally not reset; the PRESET gate drops a write racing a reset.
  always_ff @(posedge PCLK) begin
    if (commit && PRESET && apb.PWRITE && !err) begin
`ifdef APB_SLV_PSTRB_EN
      for (int b = 0; b < NB; b++)
        if (apb.PSTRB[b]) mem[idx][b*8 +: 8] <= apb.PWDATA[b*8 +: 8];
`else
      mem[idx] <= apb.PWDATA;
`endif
    end
  end

endmodule
